// File: rtl/req_encoder_8_3.sv
// req_encoder_8_3: captures request lines into a sticky pending set and streams
// the lowest-numbered one at a time as a binary index over valid/ready.
module req_encoder_8_3 #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_index,
    output logic [N-1:0] pending,
    output logic         overflow,
    input  logic         ovf_clr
);
    logic [N-1:0] cand, low, pend_nxt;
    logic [W-1:0] low_idx;
    logic         slot_free, load, ovf_hit;

    always_comb begin
        cand = pending | req;
        // two's-complement trick isolates the lowest set bit of the candidate set
        low = cand & (~cand + N'(1));
        low_idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (cand[i]) low_idx = W'(i);
        slot_free = !out_valid || out_ready;
        load = slot_free && (|cand);
        pend_nxt = load ? (cand & ~low) : cand;
        ovf_hit = |(req & pending & ~(load ? low : '0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= '0;
            out_valid <= 1'b0;
            out_index <= '0;
            overflow  <= 1'b0;
        end else begin
            pending  <= pend_nxt;
            overflow <= ovf_hit || (overflow && !ovf_clr);
            if (slot_free) begin
                out_valid <= load;
                if (load) out_index <= low_idx;
            end
        end
    end
endmodule

// File: tb/tb_req_encoder_8_3.sv
// tb_req_encoder_8_3: directed scenarios plus randomized traffic checked against
// a per-line behavioural model of the pending set and output slot.
module tb_req_encoder_8_3;
    localparam int N = 8;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_index;
    logic [N-1:0] pending;
    logic         overflow;
    logic         ovf_clr = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    bit m_pend [N];
    bit m_valid;
    int m_idx;
    bit m_ovf;

    req_encoder_8_3 #(.N(N), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .out_valid(out_valid),
        .out_ready(out_ready), .out_index(out_index), .pending(pending),
        .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        req = '0; out_ready = 1'b0; ovf_clr = 1'b0;
        #3 rst_n = 1'b1;
        foreach (m_pend[i]) m_pend[i] = 0;
        m_valid = 0; m_idx = 0; m_ovf = 0;
        tick();
    endtask

    // one clock edge of the behavioural model: lines are events, the slot holds one index
    task automatic model_step(input logic [N-1:0] r, input bit rdy, input bit clr);
        bit free;
        bit hit;
        int lowest;
        free = !m_valid || rdy;
        hit = 0;
        lowest = -1;
        for (int i = 0; i < N; i++)
            if ((m_pend[i] || r[i]) && lowest < 0) lowest = i;
        for (int i = 0; i < N; i++) begin
            bit taken;
            taken = free && (i == lowest);
            if (r[i] && m_pend[i] && !taken) hit = 1;
            m_pend[i] = (m_pend[i] || r[i]) && !taken;
        end
        if (free) begin
            m_valid = (lowest >= 0);
            if (lowest >= 0) m_idx = lowest;
        end
        m_ovf = hit || (m_ovf && !clr);
    endtask

    function automatic logic [N-1:0] model_pend();
        logic [N-1:0] p;
        for (int i = 0; i < N; i++) p[i] = m_pend[i];
        return p;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, out_index, pending, overflow} !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: got v=%b i=%0d p=%h o=%b, want all 0", out_valid, out_index, pending, overflow);
        end
        tick();
        #2 rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_checks++;
            if ({out_valid, out_index, pending, overflow} !== '0) begin
                n_fail++;
                $display("FAIL reset_idle[%0d]: got v=%b i=%0d p=%h o=%b, want all 0", c, out_valid, out_index, pending, overflow);
            end
        end
    endtask

    task automatic test_priority();
        logic [W-1:0] exp_i [3] = '{3'd2, 3'd5, 3'd7};
        logic [N-1:0] exp_p [3] = '{8'hA0, 8'h80, 8'h00};
        do_reset();
        out_ready = 1'b1;
        req = 8'b1010_0100;
        for (int c = 0; c < 3; c++) begin
            tick();
            req = '0;
            n_checks++;
            if (out_valid !== 1'b1 || out_index !== exp_i[c] || pending !== exp_p[c]) begin
                n_fail++;
                $display("FAIL priority[%0d]: got v=%b i=%0d p=%h, want v=1 i=%0d p=%h", c, out_valid, out_index, pending, exp_i[c], exp_p[c]);
            end
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || pending !== '0) begin
            n_fail++;
            $display("FAIL priority_drain: got v=%b p=%h, want v=0 p=00", out_valid, pending);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        req = 8'h40;
        tick();
        req = '0;
        tick();
        req = 8'h02;
        tick();
        req = '0;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_index !== 3'd6 || pending !== 8'h02) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got v=%b i=%0d p=%h, want v=1 i=6 p=02", c, out_valid, out_index, pending);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_index !== 3'd1 || pending !== 8'h00) begin
            n_fail++;
            $display("FAIL bp_release: got v=%b i=%0d p=%h, want v=1 i=1 p=00", out_valid, out_index, pending);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: got v=%b, want v=0", out_valid);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            req = 8'h08;
            tick();
            req = '0;
            n_checks++;
            if (overflow !== (k == 2)) begin
                n_fail++;
                $display("FAIL ovf_pulse[%0d]: got o=%b, want o=%b", k, overflow, k == 2);
            end
            tick();
        end
        tick();
        n_checks++;
        if (overflow !== 1'b1 || out_index !== 3'd3 || pending !== 8'h08) begin
            n_fail++;
            $display("FAIL ovf_sticky: got o=%b i=%0d p=%h, want o=1 i=3 p=08", overflow, out_index, pending);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: got o=%b, want o=0", overflow);
        end
        req = 8'h08;
        ovf_clr = 1'b1;
        tick();
        req = '0;
        ovf_clr = 1'b0;
        n_checks++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set_wins: got o=%b, want o=1", overflow);
        end
    endtask

    task automatic test_rerequest();
        do_reset();
        out_ready = 1'b1;
        req = 8'h10;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_index !== 3'd4 || pending !== 8'h00 || overflow !== 1'b0) begin
                n_fail++;
                $display("FAIL rereq[%0d]: got v=%b i=%0d p=%h o=%b, want v=1 i=4 p=00 o=0", c, out_valid, out_index, pending, overflow);
            end
        end
        req = '0;
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL rereq_drain: got v=%b o=%b, want v=0 o=0", out_valid, overflow);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 8'hF0;
        tick();
        req = 8'h10;
        tick();
        req = '0;
        n_checks++;
        if (out_valid !== 1'b1 || out_index !== 3'd4 || pending !== 8'hF0) begin
            n_fail++;
            $display("FAIL arst_setup: got v=%b i=%0d p=%h, want v=1 i=4 p=f0", out_valid, out_index, pending);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, out_index, pending, overflow} !== '0) begin
            n_fail++;
            $display("FAIL arst_immediate: got v=%b i=%0d p=%h o=%b, want all 0", out_valid, out_index, pending, overflow);
        end
        #1 rst_n = 1'b1;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            logic [N-1:0] r;
            r = N'($urandom) & N'($urandom) & N'($urandom);
            req = r;
            out_ready = ($urandom_range(0, 2) != 0);
            ovf_clr = ($urandom_range(0, 9) == 0);
            model_step(req, out_ready, ovf_clr);
            tick();
            n_checks++;
            if (out_valid !== m_valid || (m_valid && out_index !== W'(m_idx)) || pending !== model_pend() || overflow !== m_ovf) begin
                n_fail++;
                $display("FAIL random[%0d]: got v=%b i=%0d p=%h o=%b, want v=%b i=%0d p=%h o=%b", c, out_valid, out_index, pending, overflow, m_valid, m_idx, model_pend(), m_ovf);
            end
        end
        req = '0;
        out_ready = 1'b0;
        ovf_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_priority();
        test_backpressure();
        test_overflow();
        test_rerequest();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
